// File: rtl/seg_to_rank_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_to_rank_decoder_if
//   Bundles the sample stream and the rank handshake of seg_to_rank_decoder.
//
//   Signals:
//     seg_in          7-bit segment pattern, bit0=a ... bit6=g, 1=lit
//     seg_valid_in    seg_in is a valid sample this cycle
//     rank_out        decoded rank, 1=Ace ... 13=King
//     rank_valid_out  rank_out holds an unconsumed rank
//     rank_ready_in   consumer accepts rank_out this cycle
//     error_out       one-cycle pulse after an unrecognised valid sample
//
//   Handshake: a rank transfers on every rising clk edge where
//   rank_valid_out and rank_ready_in are both high. While rank_valid_out is
//   high and rank_ready_in is low, rank_out is held stable. rank_valid_out
//   never depends combinationally on rank_ready_in.
//
//   Modports:
//     master  sample source / rank consumer (drives seg_*, rank_ready_in)
//     slave   the decoder
// ---------------------------------------------------------------------------
interface seg_to_rank_decoder_if;
    logic [6:0] seg_in;
    logic       seg_valid_in;
    logic [3:0] rank_out;
    logic       rank_valid_out;
    logic       rank_ready_in;
    logic       error_out;

    modport master (
        output seg_in,
        output seg_valid_in,
        output rank_ready_in,
        input  rank_out,
        input  rank_valid_out,
        input  error_out
    );

    modport slave (
        input  seg_in,
        input  seg_valid_in,
        input  rank_ready_in,
        output rank_out,
        output rank_valid_out,
        output error_out
    );
endinterface

// File: rtl/seg_to_rank_decoder.sv
// ---------------------------------------------------------------------------
// seg_to_rank_decoder
//   Recovers a 4-bit card rank from a stream of sampled seven-segment
//   patterns. A rank is presented once, through a valid/ready handshake,
//   after it has been seen on STABLE_COUNT consecutive valid samples.
//   Blank (all segments off) clears the run silently; any unrecognised
//   pattern clears the run and pulses error_out for one cycle.
//
//   Ports:
//     clk_in  system clock
//     rst_in  asynchronous, active-high reset
//     bus     seg_to_rank_decoder_if.slave (sample input, rank handshake,
//             error pulse)
//
//   Parameters:
//     STABLE_COUNT  consecutive identical valid samples required (>= 1)
// ---------------------------------------------------------------------------
module seg_to_rank_decoder #(
    parameter int STABLE_COUNT = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    seg_to_rank_decoder_if.slave        bus
);

    localparam int             CW      = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_COUNT);

    // Decoded view of the current sample
    logic [3:0] dec_rank;
    logic       dec_known;
    logic       dec_blank;

    // Run tracking and output registers
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [3:0]    last_emitted;
    logic [3:0]    rank_q;
    logic          rank_valid_q;
    logic          error_q;

    logic          slot_free;
    logic          emit;

    always_comb begin
        dec_rank  = 4'd0;
        dec_known = 1'b1;
        dec_blank = 1'b0;
        case (bus.seg_in)
            7'h77:   dec_rank = 4'd1;
            7'h5B:   dec_rank = 4'd2;
            7'h4F:   dec_rank = 4'd3;
            7'h66:   dec_rank = 4'd4;
            7'h6D:   dec_rank = 4'd5;
            7'h7D:   dec_rank = 4'd6;
            7'h27:   dec_rank = 4'd7;
            7'h7F:   dec_rank = 4'd8;
            7'h6F:   dec_rank = 4'd9;
            7'h3F:   dec_rank = 4'd10;
            7'h1F:   dec_rank = 4'd11;
            7'h67:   dec_rank = 4'd12;
            7'h56:   dec_rank = 4'd13;
            7'h00: begin
                dec_known = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_known = 1'b0;
        endcase
    end

    // cnt only reaches CNT_MAX with a known (non-zero) cand, so comparing
    // against last_emitted is enough to suppress re-emission of a held card.
    // The emit condition stays true while cnt is saturated, which is what
    // carries a rank across backpressure.
    assign slot_free = !rank_valid_q || bus.rank_ready_in;
    assign emit      = (cnt == CNT_MAX) && (cand != last_emitted) && slot_free;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cand         <= 4'd0;
            cnt          <= '0;
            last_emitted <= 4'd0;
            rank_q       <= 4'd0;
            rank_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // Output slot: emit (possibly back-to-back with a transfer) or drain.
            if (emit) begin
                rank_q       <= cand;
                rank_valid_q <= 1'b1;
                last_emitted <= cand;
            end else if (rank_valid_q && bus.rank_ready_in) begin
                rank_valid_q <= 1'b0;
            end

            error_q <= bus.seg_valid_in && !dec_known && !dec_blank;

            // Sample capture. Placed after the emit so that a blank/unknown
            // arriving on the emit edge still clears last_emitted: the card
            // was removed, so it may be reported again when it returns.
            if (bus.seg_valid_in) begin
                if (dec_known) begin
                    if ((dec_rank == cand) && (cnt != '0)) begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cand <= dec_rank;
                        cnt  <= CW'(1);
                    end
                end else begin
                    cand         <= 4'd0;
                    cnt          <= '0;
                    last_emitted <= 4'd0;
                end
            end
        end
    end

    assign bus.rank_out       = rank_q;
    assign bus.rank_valid_out = rank_valid_q;
    assign bus.error_out      = error_q;

endmodule

// File: tb/tb_seg_to_rank_decoder.sv
module tb_seg_to_rank_decoder;

    localparam int SC = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_to_rank_decoder_if bif ();

    seg_to_rank_decoder #(.STABLE_COUNT(SC)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bif)
    );

    // ---------------- counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int seen13 = 0;
    int err_pulses = 0;

    // ---------------- reference model ----------------
    // Pattern table: entry i is the display pattern of rank i+1.
    logic [6:0] pat_tab [13] = '{7'h77, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                                 7'h7F, 7'h6F, 7'h3F, 7'h1F, 7'h67, 7'h56};

    int         run_rank  = 0;  // rank of the current unbroken run (0 = none)
    int         run_len   = 0;  // unbounded length of that run
    int         last_emit = 0;
    logic       m_valid   = 1'b0;
    logic [3:0] m_rank    = 4'd0;
    logic       m_err     = 1'b0;

    // Returns 1..13 for a card, 0 for blank, -1 for anything else.
    function automatic int lookup(input logic [6:0] s);
        if (s == 7'h00) return 0;
        for (int i = 0; i < 13; i++)
            if (pat_tab[i] == s) return i + 1;
        return -1;
    endfunction

    function automatic void model_reset();
        run_rank = 0; run_len = 0; last_emit = 0;
        m_valid = 1'b0; m_rank = 4'd0; m_err = 1'b0;
    endfunction

    // Advance the model across one clock edge given the inputs seen there.
    function automatic void model_step(input logic [6:0] s, input logic v, input logic r);
        int  d;
        bit  fire;
        fire = (run_len >= SC) && (run_rank != last_emit) && (!m_valid || r);
        if (fire) begin
            m_rank    = 4'(run_rank);
            m_valid   = 1'b1;
            last_emit = run_rank;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        d = lookup(s);
        m_err = v && (d < 0);
        if (v) begin
            if (d > 0) begin
                if (d == run_rank && run_len > 0) run_len++;
                else begin run_rank = d; run_len = 1; end
            end else begin
                run_rank = 0; run_len = 0; last_emit = 0;
            end
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Entered just after a rising edge. Drives inputs for one cycle, compares
    // outputs mid-cycle against the model, then advances the model at the edge.
    task automatic cycle(input logic [6:0] s, input logic v, input logic r);
        bif.seg_in        = s;
        bif.seg_valid_in  = v;
        bif.rank_ready_in = r;
        @(negedge clk);
        chk("rank_valid", {3'b0, bif.rank_valid_out}, {3'b0, m_valid});
        chk("rank_out",   bif.rank_out,               m_rank);
        chk("error",      {3'b0, bif.error_out},      {3'b0, m_err});
        if (bif.rank_valid_out && r && bif.rank_out == 4'd13) seen13++;
        if (bif.error_out) err_pulses++;
        model_step(s, v, r);
        @(posedge clk);
        #1;
    endtask

    task automatic rep(input logic [6:0] s, input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(s, 1'b1, r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(7'h00, 1'b0, r);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] cur;
        int         sel;
        int         e0;

        bif.seg_in        = 7'h00;
        bif.seg_valid_in  = 1'b0;
        bif.rank_ready_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2, 1'b0);

        // Reset while a rank is pending
        rep(7'h77, 4, 1'b0);
        idle(2, 1'b0);
        chk("pending_before_reset", {3'b0, bif.rank_valid_out}, 4'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {3'b0, bif.rank_valid_out}, 4'd0);
        chk("rst_rank",  bif.rank_out,               4'd0);
        chk("rst_error", {3'b0, bif.error_out},      4'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rep(7'h77, 4, 1'b0);
        idle(1, 1'b0);
        chk("post_reset_valid", {3'b0, bif.rank_valid_out}, 4'd1);
        chk("post_reset_rank",  bif.rank_out,               4'd1);
        idle(1, 1'b1);
        idle(1, 1'b0);

        // Handshake hold and single emission of a held card
        rep(7'h7F, 4, 1'b0);
        rep(7'h7F, 10, 1'b0);
        chk("hold_rank", bif.rank_out, 4'd8);
        cycle(7'h7F, 1'b1, 1'b1);
        rep(7'h7F, 20, 1'b0);
        chk("no_reemit", {3'b0, bif.rank_valid_out}, 4'd0);

        // Instability: 13 never qualifies, 11 does
        rep(7'h56, 3, 1'b1);
        rep(7'h1F, 4, 1'b1);
        idle(3, 1'b1);
        chk("never_13", 4'(seen13), 4'd0);

        // Unknown pattern inside a run
        e0 = err_pulses;
        rep(7'h77, 2, 1'b1);
        cycle(7'h01, 1'b1, 1'b1);
        rep(7'h77, 4, 1'b1);
        idle(3, 1'b1);
        chk("one_err_pulse", 4'(err_pulses - e0), 4'd1);

        // Gaps do not break a run; blank re-arms the same rank
        for (int i = 0; i < 8; i++) cycle(7'h5B, (i % 2) == 0, 1'b1);
        idle(2, 1'b1);
        cycle(7'h00, 1'b1, 1'b1);
        rep(7'h5B, 4, 1'b1);
        idle(3, 1'b1);

        // Backpressure chain with back-to-back load
        rep(7'h77, 4, 1'b0);
        idle(1, 1'b0);
        rep(7'h5B, 6, 1'b0);
        chk("bp_hold_rank", bif.rank_out, 4'd1);
        idle(1, 1'b1);
        chk("b2b_valid", {3'b0, bif.rank_valid_out}, 4'd1);
        chk("b2b_rank",  bif.rank_out,               4'd2);
        idle(2, 1'b1);

        // Randomised soak: runs of a few cards with blanks, junk, gaps, stalls
        cur = 7'h77;
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 11));
            if (sel < 4)       cur = pat_tab[$urandom_range(0, 12)];
            else if (sel == 4) cur = 7'h00;
            else if (sel == 5) cur = 7'($urandom_range(1, 127));
            cycle(cur, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_to_rank_decoder.md
Name: seg_to_rank_decoder

Overview:
- Inverse of the card-rank seven-segment encoder: accepts a stream of sampled 7-segment patterns and recovers the 4-bit card rank code.
- Example sources are a segment-detection stage or a loopback of the display bus.
- A rank is reported only after it has been seen stably for STABLE_COUNT consecutive valid samples. It is then presented once through a valid/ready handshake.
- Unrecognised patterns are flagged.

Parameters:
STABLE_COUNT, 4, consecutive identical valid samples required before a rank qualifies (legal range >=1); counter width is $clog2(STABLE_COUNT+1).

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
seg_in  input  7  segment pattern, bit0=a ... bit6=g, 1=lit
seg_valid_in  input  1  seg_in is a valid sample this cycle
rank_out  output  4  decoded rank, 1=Ace ... 13=King
rank_valid_out  output  1  rank_out holds an unconsumed rank
rank_ready_in  input  1  consumer accepts rank_out this cycle
error_out  output  1  one-cycle pulse: last valid sample was an unrecognised pattern

Behaviour:
- Decode table (seg_in hex -> rank):
  - 77->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 27->7
  - 7F->8, 6F->9, 3F->10, 1F->11, 67->12, 56->13
  - 00 -> blank (no card)
  - Every other pattern is unknown.
- Reset (async, rst_in=1): rank_out=0, rank_valid_out=0, error_out=0. Internal cand=0, cnt=0, last_emitted=0. Takes effect immediately, including mid-handshake; any pending rank is discarded.
- Sample capture happens only at clock edges where seg_valid_in=1. Cycles with seg_valid_in=0 change nothing (gaps do not break a run).
- Valid sample, known rank equal to cand with cnt>0: cnt <- min(cnt+1, STABLE_COUNT).
- Valid sample, known rank differing from cand, or cnt=0: cand <- rank, cnt <- 1.
- Valid sample, blank: cand <- 0, cnt <- 0, last_emitted <- 0. No error.
- Valid sample, unknown: cand <- 0, cnt <- 0, last_emitted <- 0, error_out=1 in the following cycle only.
- Emit condition, evaluated every cycle:
  - cnt==STABLE_COUNT, and
  - cand != last_emitted, and
  - output slot free (rank_valid_out=0 or rank_ready_in=1).
- On emit (registered): rank_out <- cand, rank_valid_out <- 1, last_emitted <- cand.
- Latency: N=STABLE_COUNT consecutive identical samples on cycles 0..N-1 give rank_valid_out=1 in cycle N+1.
- Handshake:
  - Transfer occurs when rank_valid_out and rank_ready_in are both high.
  - rank_out is stable while valid and not ready.
  - After a transfer with no new emit, rank_valid_out <- 0; rank_out keeps its last value.
  - Transfer and new emit in the same cycle: rank_valid_out stays 1 and rank_out updates (back-to-back).
- Backpressure: a rank that qualifies while the slot is full is not lost. The emit condition remains true while cnt stays saturated, so it emits the cycle after the slot frees. If the run breaks first, the rank is not emitted.
- A card held steady emits exactly once. Re-emission of the same rank requires an intervening blank, unknown, or different qualified rank.
- A different rank that never reaches STABLE_COUNT is never emitted.
- Simultaneous seg_valid_in and emit: the emit uses pre-edge cand/cnt; the new sample updates cand/cnt at the same edge.

Test Plan:
- Reset: drive rst_in high mid-run with rank_valid_out=1 -> all outputs 0 immediately. Continue 77 x4 after release -> rank_out=1, valid in cycle 5 after first sample.
- Handshake hold: 7F x4 with rank_ready_in=0 for 10 cycles -> rank_out=8, valid held steady. Raise ready for 1 cycle -> valid drops next cycle; no second emit while 7F continues for 20 more samples.
- Instability: 56,56,56,1F,1F,1F,1F -> only rank 11 emitted; 13 never appears.
- Unknown: 77,77,01,77,77,77,77 -> error_out pulses once, one cycle after the 01 sample. Rank 1 emitted only after the last four 77s.
- Gaps and re-present: 5B samples interleaved with seg_valid_in=0 gaps -> rank 2 emitted after 4 valid samples. Then 00, then 5B x4 -> rank 2 emitted again.
- Backpressure chain: 77 x4 emitted, ready=0, then 5B x6 -> rank_out stays 1. Assert ready -> the same edge loads rank 2, so valid stays high and rank_out=2 next cycle.
